// File: rtl/ififo_bank_skew_if.sv
// ---------------------------------------------------------------------------
// ififo_bank_skew_if
// Bundles the data/handshake side of the column FIFO bank.
//   master : producer/consumer side (drives writes, reads, clr_err)
//   slave  : the FIFO bank (drives read data, flags, occupancy, errors)
// Signals:
//   wr_en[COL], in_col[COL*BW]        per-column write enable and data
//   rd_en[COL], clr_err               per-column read request, error clear
//   out_col[COL*BW], out_valid[COL]   registered read data and its valid
//   o_full, o_afull, o_ready          bank-wide status
//   count_flat[COL*(AW+1)]            per-column occupancy
//   err_ovf, err_udf                  sticky overflow/underflow flags
// ---------------------------------------------------------------------------
interface ififo_bank_skew_if #(
    parameter int COL   = 8,
    parameter int BW    = 4,
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);

    logic [COL-1:0]         wr_en;
    logic [COL*BW-1:0]      in_col;
    logic [COL-1:0]         rd_en;
    logic                   clr_err;
    logic [COL*BW-1:0]      out_col;
    logic [COL-1:0]         out_valid;
    logic                   o_full;
    logic                   o_afull;
    logic                   o_ready;
    logic [COL*(AW+1)-1:0]  count_flat;
    logic                   err_ovf;
    logic                   err_udf;

    modport master (
        output wr_en, in_col, rd_en, clr_err,
        input  out_col, out_valid, o_full, o_afull, o_ready, count_flat,
               err_ovf, err_udf
    );

    modport slave (
        input  wr_en, in_col, rd_en, clr_err,
        output out_col, out_valid, o_full, o_afull, o_ready, count_flat,
               err_ovf, err_udf
    );
endinterface

// File: rtl/ififo_bank_skew.sv
// ---------------------------------------------------------------------------
// ififo_bank_skew
// Bank of COL independent circular-buffer FIFOs (DEPTH x BW each) feeding a
// systolic array. Each column has its own pointers and occupancy count;
// only the status flags and sticky error flags are shared across columns.
//
// Optional feature (macro IFIFO_SKEW_EN): the read request of column 0 is
// propagated diagonally, column c reading c cycles after column 0, through
// a COL-1 stage shift register. rd_en[COL-1:1] are ignored in that mode.
// Without the macro each column reads on its own rd_en bit.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : ififo_bank_skew_if.slave (see interface file for signals)
// ---------------------------------------------------------------------------

// One column: circular buffer, registered read port, error events.
module ififo_bank_col #(
    parameter int BW    = 4,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [BW-1:0] wdata,
    input  logic          rd,
    output logic [BW-1:0] rdata,
    output logic          valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ovf_evt,
    output logic          udf_evt
);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [BW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [BW-1:0] rdata_q, rdata_d;
    logic          valid_q, valid_d;
    logic          rd_acc, wr_acc;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    always_comb begin
        // A write into a full column still lands when a read frees a slot
        // in the same cycle; a read never sees a same-cycle write.
        rd_acc  = rd && !empty;
        wr_acc  = wr_en && (!full || rd_acc);
        ovf_evt = wr_en && full && !rd_acc;
        udf_evt = rd && empty;

        wptr_d  = wr_acc ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = rd_acc ? rptr_q + 1'b1 : rptr_q;

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        rdata_d = rd_acc ? mem_q[rptr_q] : rdata_q;
        valid_d = rd_acc;
    end

    // Storage needs no reset: pointer/count reset makes old contents dead.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    assign rdata = rdata_q;
    assign valid = valid_q;
    assign count = count_q;
endmodule

module ififo_bank_skew #(
    parameter int COL       = 8,
    parameter int BW        = 4,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = DEPTH - 4
) (
    input  logic               clk,
    input  logic               reset,
    ififo_bank_skew_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    logic [COL-1:0]          eff_rd;
    logic [COL-1:0]          full, empty, afull, ovf_evt, udf_evt, vld;
    logic [COL-1:0][BW-1:0]  rdata;
    logic [COL-1:0][AW:0]    cnt;
    logic                    err_ovf_q, err_ovf_d;
    logic                    err_udf_q, err_udf_d;

`ifdef IFIFO_SKEW_EN
    // Diagonal feed: stage c holds column 0's request from c cycles ago.
    logic [COL-1:1] skew_q, skew_d;
    logic           skew_unused;

    assign skew_unused = ^bus.rd_en[COL-1:1];
    assign eff_rd      = {skew_q, bus.rd_en[0]};

    always_comb begin
        skew_d = eff_rd[COL-2:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) skew_q <= '0;
        else        skew_q <= skew_d;
    end
`else
    assign eff_rd = bus.rd_en;
`endif

    for (genvar g = 0; g < COL; g++) begin : g_col
        ififo_bank_col #(
            .BW    (BW),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_col (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (bus.wr_en[g]),
            .wdata   (bus.in_col[g*BW +: BW]),
            .rd      (eff_rd[g]),
            .rdata   (rdata[g]),
            .valid   (vld[g]),
            .count   (cnt[g]),
            .full    (full[g]),
            .empty   (empty[g]),
            .ovf_evt (ovf_evt[g]),
            .udf_evt (udf_evt[g])
        );
    end

    always_comb begin
        afull = '0;
        for (int c = 0; c < COL; c++) begin
            afull[c] = (32'(cnt[c]) >= AF_THRESH);
        end
    end

    // A fresh error outranks a same-cycle clear.
    always_comb begin
        err_ovf_d = (|ovf_evt) || (err_ovf_q && !bus.clr_err);
        err_udf_d = (|udf_evt) || (err_udf_q && !bus.clr_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign bus.out_col    = rdata;
    assign bus.out_valid  = vld;
    assign bus.count_flat = cnt;
    assign bus.o_full     = |full;
    assign bus.o_afull    = |afull;
    assign bus.o_ready    = &(~empty);
    assign bus.err_ovf    = err_ovf_q;
    assign bus.err_udf    = err_udf_q;
endmodule

// File: doc/ififo_bank_skew.md
IFIFO_BANK_SKEW -- requirements
Module: ififo_bank_skew

Interface
REQ-001 Parameter COL, default 8: number of independent column FIFOs.
REQ-002 Parameter BW, default 4: word width per column in bits.
REQ-003 Parameter DEPTH, default 64: entries per column; power of two, >=2; AW = log2(DEPTH).
REQ-004 Parameter AF_THRESH, default DEPTH-4: per-column almost-full occupancy threshold.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-007 wr_en  in  COL  per-column write enable.
REQ-008 in_col  in  COL*BW  write data; column c at bits [(c+1)*BW-1 : c*BW].
REQ-009 rd_en  in  COL  per-column read request (skew mode: only bit 0 used, see REQ-030).
REQ-010 clr_err  in  1  synchronous clear of sticky error flags.
REQ-011 out_col  out  COL*BW  registered read data, same column packing as in_col.
REQ-012 out_valid  out  COL  per-column pulse: out_col slice holds data read on previous cycle.
REQ-013 o_full  out  1  OR of per-column full.
REQ-014 o_afull  out  1  OR of per-column (count >= AF_THRESH).
REQ-015 o_ready  out  1  AND of per-column non-empty.
REQ-016 count_flat  out  COL*(AW+1)  per-column occupancy 0..DEPTH, packed like in_col.
REQ-017 err_ovf / err_udf  out  1 each  sticky overflow / underflow flags.

Function
REQ-018 Each column SHALL be a circular buffer with AW-bit read/write pointers and an (AW+1)-bit count; pointers wrap DEPTH-1 -> 0.
REQ-019 Write accepted when wr_en[c]=1 and (count<DEPTH or read accepted same cycle); accepted write stores in_col slice at wptr, wptr+1.
REQ-020 Write with wr_en[c]=1 while full and no accepted read SHALL be dropped, state unchanged, err_ovf set next cycle.
REQ-021 Read accepted when effective read[c]=1 and count>0; rptr+1; data registered into out_col slice; out_valid[c]=1 exactly one cycle later.
REQ-022 Read request while count=0 SHALL be ignored (no fall-through of a same-cycle write), out_valid[c]=0 next cycle, err_udf set next cycle.
REQ-023 Simultaneous accepted read and write: count unchanged; when full both succeed; when empty only the write succeeds (REQ-022 applies).
REQ-024 out_col slice SHALL hold its last value when no read is accepted; out_valid[c] deasserts.
REQ-025 count SHALL equal accepted writes minus accepted reads; never exceeds DEPTH, never below 0.
REQ-026 o_full, o_afull, o_ready, count_flat SHALL be combinational from registered state (no input-to-output paths).
REQ-027 clr_err=1 clears both error flags next cycle; a new error in the same cycle takes priority (flag set).
REQ-028 Columns SHALL be fully independent except shared flags of REQ-013..015, REQ-017.

Reset
REQ-029 While reset=0: all pointers and counts 0, out_col all zero, out_valid 0, err_ovf/err_udf 0, hence o_full=0, o_afull=0 (when AF_THRESH>0), o_ready=0; asserting mid-operation discards all stored data immediately.

Configuration
REQ-030 Macro IFIFO_SKEW_EN defined: effective read[0]=rd_en[0], read[c]=rd_en[0] delayed c cycles through a COL-1 stage shift register reset to 0; rd_en[COL-1:1] ignored; systolic diagonal feed.
REQ-031 IFIFO_SKEW_EN undefined: effective read[c]=rd_en[c]; no shift register instantiated.
REQ-032 Error rules of REQ-020..022 apply to effective reads in both modes.

Verification (COL=4, BW=4, DEPTH=8, AF_THRESH=6)
REQ-033 Reset, write 8 words 0x1..0x8 to all columns -> count=8 each, o_full=1, o_afull=1 after 6th write, o_ready=1 after 1st.
REQ-034 Read column 2 only, 8 cycles -> out_col[11:8]=0x1..0x8 on consecutive cycles, out_valid[2] one cycle after each read, count_flat col2=0.
REQ-035 Column 0 full; wr_en[0]=1 with no read -> data dropped, err_ovf=1; pulse clr_err -> err_ovf=0; same with rd_en[0]=1 -> both accepted, count stays 8.
REQ-036 Empty column 1; wr_en[1]=1 and rd_en[1]=1 same cycle -> count=1, out_valid[1]=0, err_udf=1.
REQ-037 IFIFO_SKEW_EN, columns loaded with 0xA; rd_en[0] high 1 cycle -> out_valid[c] pulses at cycle c+1 for c=0..3.
REQ-038 Write 10 then read 10 across pointer wrap; assert reset=0 mid-burst -> all outputs zero immediately, counts 0.
